oled_spi_tx: RTL and testbench

Byte-serial SPI transmitter that sits between the OLED command/data sequencers (power-up init, frame writer) and the SSD1306 panel pins. It accepts one byte plus its D/C flag on a level-held `spi_send` request. It shifts the byte out MSB-first in SPI mode 0 and returns a one-cycle `send_done` pulse, which the sequencer uses to advance its state. It is the responder end of the `spi_send` / `spi_data` / `send_done` handshake used by every OLED sequencer in the design.

---
 rtl/oled_spi_tx.sv | 158 +++++++++++++++
 tb/tb_oled_spi_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_tx.sv
// oled_spi_tx: byte-serial SPI (mode 0) transmitter for an SSD1306 panel.
// Accepts one byte plus its D/C flag on a level-held request and shifts it
// out MSB first. Returns a one-cycle send_done pulse when CS is released.
module oled_spi_tx #(
  parameter int unsigned CLK_DIV = 4  // SCLK half-period in clk cycles, 1..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_send,
  input  logic [7:0] spi_data,
  input  logic       dc,
  output logic       send_done,
  output logic       busy,
  output logic       oled_sclk,
  output logic       oled_sdin,
  output logic       oled_cs_n,
  output logic       oled_dc
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_DONE
  } state_t;

  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] phase_q, phase_d;   // cycles spent in the current SCLK phase
  logic [2:0] bit_q,   bit_d;     // index of the bit on the wire, 0 = MSB
  logic       last_q,  last_d;    // set once bit 7 has been clocked out
  logic [7:0] shreg_q, shreg_d;   // shreg_q[7] is the bit currently on SDIN
  logic       done_d, busy_d, sclk_d, sdin_d, cs_n_d, dc_d;
  logic       phase_end;

  assign phase_end = (phase_q == PHASE_LAST);

  // State, counters and every output pin are registered here.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      last_q    <= 1'b0;
      shreg_q   <= '0;
      send_done <= 1'b0;
      busy      <= 1'b0;
      oled_sclk <= 1'b0;
      oled_sdin <= 1'b0;
      oled_cs_n <= 1'b1;
      oled_dc   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      last_q    <= last_d;
      shreg_q   <= shreg_d;
      send_done <= done_d;
      busy      <= busy_d;
      oled_sclk <= sclk_d;
      oled_sdin <= sdin_d;
      oled_cs_n <= cs_n_d;
      oled_dc   <= dc_d;
    end
  end

  // Next-state and next-output decode for the shift sequence.
  always_comb begin
    // NOTE: each target defaults to its held value before the case so no latch is inferred.
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    last_d  = last_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    sclk_d  = oled_sclk;
    sdin_d  = oled_sdin;
    cs_n_d  = oled_cs_n;
    dc_d    = oled_dc;

    case (state_q)
      ST_IDLE: begin
        if (spi_send) begin
          shreg_d = spi_data;
          dc_d    = dc;
          cs_n_d  = 1'b0;
          sdin_d  = spi_data[7];
          phase_d = '0;
          bit_d   = '0;
          last_d  = 1'b0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (phase_end) begin
          phase_d = '0;
          sclk_d  = 1'b1;
          state_d = ST_SHIFT_HI;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      ST_SHIFT_HI: begin
        if (phase_end) begin
          phase_d = '0;
          sclk_d  = 1'b0;
          state_d = ST_SHIFT_LO;
          // The next bit goes out on the same falling edge, giving a full
          // half-period of setup before the following rising edge.
          if (bit_q == 3'd7) begin
            last_d = 1'b1;
          end else begin
            shreg_d = {shreg_q[6:0], 1'b0};
            sdin_d  = shreg_q[6];
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      ST_SHIFT_LO: begin
        if (phase_end) begin
          phase_d = '0;
          if (last_q) begin
            done_d  = 1'b1;
            cs_n_d  = 1'b1;
            sdin_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            bit_d   = bit_q + 3'd1;
            sclk_d  = 1'b1;
            state_d = ST_SHIFT_HI;
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      ST_DONE: begin
        // spi_send is deliberately not looked at here, nor on the edge that
        // enters IDLE, so a held request cannot resend the finished byte.
        last_d  = 1'b0;
        bit_d   = '0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_oled_spi_tx.sv
// Testbench for oled_spi_tx: a sequencer-style driver pushes expected bytes
// and accept times into a scoreboard; a bus monitor decodes the SPI pins and
// checks each byte when send_done pulses.
module tb_oled_spi_tx;

  localparam int D = 4;

  typedef struct {
    logic [7:0] data;
    logic       dc;
    int         e0;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_send = 1'b0;
  logic [7:0] spi_data = '0;
  logic       dc = 1'b0;
  logic       send_done, busy, oled_sclk, oled_sdin, oled_cs_n, oled_dc;

  logic       send1 = 1'b0;
  logic [7:0] data1 = '0;
  logic       dc1 = 1'b0;
  logic       done1_o, busy1, sclk1, sdin1, cs1_n, dc1_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int free_at = 0;
  exp_t exp_q[$];

  oled_spi_tx #(.CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .spi_send(spi_send), .spi_data(spi_data), .dc(dc),
    .send_done(send_done), .busy(busy), .oled_sclk(oled_sclk), .oled_sdin(oled_sdin),
    .oled_cs_n(oled_cs_n), .oled_dc(oled_dc)
  );

  oled_spi_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .spi_send(send1), .spi_data(data1), .dc(dc1),
    .send_done(done1_o), .busy(busy1), .oled_sclk(sclk1), .oled_sdin(sdin1),
    .oled_cs_n(cs1_n), .oled_dc(dc1_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a byte is accepted at the first edge that sees the request and is
  // at least 17D+2 edges after the previous accept.
  task automatic present(input logic [7:0] d, input logic c);
    exp_t e;
    spi_send = 1'b1;
    spi_data = d;
    dc       = c;
    e.data = d;
    e.dc   = c;
    e.e0   = (cyc + 1 > free_at) ? cyc + 1 : free_at;
    free_at = e.e0 + 17 * D + 2;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!send_done && n < budget);
    if (!send_done) check("done_timeout", send_done, 1);
  endtask

  // Bus monitor: decodes SDIN on SCLK rising edges and scores each byte.
  logic       prev_sclk = 1'b0, prev_cs = 1'b1, prev_done = 1'b0;
  logic [7:0] mon_bits = '0;
  logic       mon_dc = 1'b0, mon_dc_bad = 1'b0;
  int         mon_e0 = 0, mon_nrise = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_sclk = 1'b0;
      prev_cs   = 1'b1;
      prev_done = 1'b0;
      mon_nrise = 0;
    end else begin
      if (prev_done) check("done_width", send_done, 0);
      if (prev_cs && !oled_cs_n) begin
        mon_e0     = cyc;
        mon_nrise  = 0;
        mon_bits   = '0;
        mon_dc     = oled_dc;
        mon_dc_bad = 1'b0;
      end
      if (!oled_cs_n && oled_dc !== mon_dc) mon_dc_bad = 1'b1;
      if (!prev_sclk && oled_sclk) begin
        if (oled_cs_n) check("sclk_while_cs_high", oled_cs_n, 0);
        check("rise_time", cyc, mon_e0 + D + 2 * mon_nrise * D);
        mon_bits  = {mon_bits[6:0], oled_sdin};
        mon_nrise = mon_nrise + 1;
      end
      if (send_done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("byte", mon_bits, e.data);
          check("dc", mon_dc, e.dc);
          check("dc_stable", mon_dc_bad, 0);
          check("rise_count", mon_nrise, 8);
          check("accept_time", mon_e0, e.e0);
          check("done_time", cyc, e.e0 + 17 * D);
          check("cs_at_done", oled_cs_n, 1);
          check("sdin_at_done", oled_sdin, 0);
        end
      end
      prev_sclk = oled_sclk;
      prev_cs   = oled_cs_n;
      prev_done = send_done;
    end
  end

  // Stimulus.
  initial begin
    logic [7:0] init_seq [11];
    logic [7:0] bits1;
    int e0a, e0b, done1_cyc, nr1, start1;
    logic psclk1, pcs1, dc_at_done1;

    init_seq = '{8'hAE, 8'hD5, 8'h80, 8'h8D, 8'h14, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hA0, 8'hAF};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_done", send_done, 0);
    check("rst_busy", busy, 0);
    check("rst_sclk", oled_sclk, 0);
    check("rst_sdin", oled_sdin, 0);
    check("rst_cs_n", oled_cs_n, 1);
    check("rst_dc", oled_dc, 0);
    check("rst_cs1_n", cs1_n, 1);
    reset   = 1'b0;
    free_at = cyc + 1;

    // Single command byte.
    @(negedge clk);
    present(8'hAE, 1'b0);
    wait_done(17 * D + 20);
    spi_send = 1'b0;

    // Init stream with a held request, advancing on send_done.
    repeat (3) @(negedge clk);
    present(init_seq[0], 1'b0);
    for (int i = 0; i < 11; i++) begin
      wait_done(17 * D + 20);
      if (i < 10) present(init_seq[i + 1], 1'b0);
      else spi_send = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("busy_after_stream", busy, 0);

    // Randomized bytes, D/C flags and inter-byte gaps.
    for (int i = 0; i < 20; i++) begin
      int gap;
      gap = int'($urandom_range(0, 5));
      spi_send = 1'b0;
      repeat (gap) @(negedge clk);
      if (gap == 0) @(negedge clk);
      present(8'($urandom), 1'($urandom));
      wait_done(17 * D + 20);
    end
    spi_send = 1'b0;

    // Inputs change mid-byte: new data/dc at bit 3 are ignored.
    repeat (4) @(negedge clk);
    present(8'hA5, 1'b0);
    repeat (D + 6 * D) @(negedge clk);
    spi_data = 8'h55;
    dc       = 1'b1;
    wait_done(17 * D + 20);
    spi_send = 1'b0;

    // Request dropped at bit 2: the byte still completes.
    repeat (4) @(negedge clk);
    present(8'hA5, 1'b0);
    repeat (D + 4 * D) @(negedge clk);
    spi_send = 1'b0;
    wait_done(17 * D + 20);

    // Reset at bit 4 of 0x3C, request held through reset.
    repeat (4) @(negedge clk);
    present(8'h3C, 1'b0);
    repeat (D + 8 * D) @(negedge clk);
    check("busy_before_abort", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("abort_done", send_done, 0);
    check("abort_busy", busy, 0);
    check("abort_sclk", oled_sclk, 0);
    check("abort_sdin", oled_sdin, 0);
    check("abort_cs_n", oled_cs_n, 1);
    check("abort_dc", oled_dc, 0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    free_at = cyc + 1;
    present(8'h3C, 1'b0);
    wait_done(17 * D + 20);
    spi_send = 1'b0;

    // Minimum divider on the second instance.
    @(negedge clk);
    send1  = 1'b1;
    data1  = 8'h01;
    dc1    = 1'b1;
    start1 = cyc;
    e0a = -1; e0b = -1; done1_cyc = -1; nr1 = 0; bits1 = '0;
    psclk1 = 1'b0; pcs1 = 1'b1; dc_at_done1 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pcs1 && !cs1_n) begin
        if (e0a < 0) e0a = cyc;
        else if (e0b < 0) e0b = cyc;
      end
      if (!psclk1 && sclk1 && e0b < 0) begin
        bits1 = {bits1[6:0], sdin1};
        nr1++;
      end
      if (done1_o && done1_cyc < 0) begin
        done1_cyc   = cyc;
        dc_at_done1 = dc1_o;
        data1 = 8'h80;
        dc1   = 1'b0;
      end
      psclk1 = sclk1;
      pcs1   = cs1_n;
    end
    send1 = 1'b0;
    check("d1_accept", e0a, start1 + 1);
    check("d1_byte", bits1, 8'h01);
    check("d1_rises", nr1, 8);
    check("d1_dc", dc_at_done1, 1);
    check("d1_done_time", done1_cyc, e0a + 17);
    check("d1_next_accept", e0b, e0a + 19);

    // Drain: no extra or missing send_done pulses.
    repeat (100) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("busy_final", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
